// File: rtl/axi4_graph_mem_rd_if.sv
// AXI4 read-address / read-data channel bundle for the graph memory responder.
interface axi4_graph_mem_rd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_graph_mem_rd_slave.sv
// AXI4 read-only INCR-burst responder backed by a preloadable 64-bit word array.
// Optional LFSR-driven rvalid bubbles between beats when AXI_RD_STALL_EN is defined.
module axi4_graph_mem_rd_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_graph_mem_rd_if.slave    s_axi,
  input  logic                  mem_wr_en,
  input  logic [IDX_WIDTH-1:0]  mem_wr_idx,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic [31:0]           beats_served
);

  localparam int WIDX = ADDR_WIDTH - 3;
  localparam logic [WIDX-1:0] DEPTH_W = WIDX'(MEM_DEPTH);
  localparam logic [31:0]     DEPTH_U = 32'(MEM_DEPTH);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  // ST_RESET holds arready low for the first edge after reset release.
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_BURST, ST_GAP} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [WIDX-1:0]       idx_q;
  logic [WIDX-1:0]       fetch_idx;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  arready;
  logic                  r_hs;
  logic                  last_beat;
  logic                  stall;
  logic                  fetch_ok;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^s_axi.araddr[2:0];

  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign r_hs      = rvalid_q && s_axi.rready;
  assign last_beat = (cnt_q == len_q);

`ifdef AXI_RD_STALL_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, free-running from reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Word fetched on the edge that registers the beat: start address in IDLE, successor in BURST.
  always_comb begin
    fetch_idx  = (state_q == ST_IDLE) ? s_axi.araddr[ADDR_WIDTH-1:3] : idx_q + WIDX'(1);
    fetch_ok   = (fetch_idx < DEPTH_W);
    fetch_data = '0;
    if (fetch_ok) begin
      fetch_data = mem[fetch_idx[IDX_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        arready = 1'b1;
        if (s_axi.arvalid) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        busy = 1'b1;
        if (r_hs) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else if (stall) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        busy    = 1'b1;
        state_d = ST_BURST;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      beats_served <= '0;
    end else if (state_q == ST_IDLE && s_axi.arvalid) begin
      idx_q    <= fetch_idx;
      len_q    <= s_axi.arlen;
      cnt_q    <= '0;
      rvalid_q <= 1'b1;
      rdata_q  <= fetch_data;
      rresp_q  <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_q  <= (s_axi.arlen == 8'd0);
    end else if (state_q == ST_BURST && r_hs) begin
      beats_served <= beats_served + 32'd1;
      if (last_beat) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        // Next beat is loaded now even when a bubble follows, so it sits ready behind rvalid=0.
        idx_q    <= fetch_idx;
        cnt_q    <= cnt_q + 8'd1;
        rdata_q  <= fetch_data;
        rresp_q  <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
        rlast_q  <= ((cnt_q + 8'd1) == len_q);
        rvalid_q <= !stall;
      end
    end else if (state_q == ST_GAP) begin
      rvalid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en && (32'(mem_wr_idx) < DEPTH_U)) begin
      mem[mem_wr_idx] <= mem_wr_data;
    end
  end

endmodule

// File: tb/tb_axi4_graph_mem_rd_slave.sv
// Self-checking bench for axi4_graph_mem_rd_slave: directed vector table, hand sequences, random bursts.
module tb_axi4_graph_mem_rd_slave;

  localparam int MEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [9:0]  mem_wr_idx = '0;
  logic [63:0] mem_wr_data = '0;
  logic        busy;
  logic [31:0] beats_served;

  axi4_graph_mem_rd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi4_graph_mem_rd_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_WIDTH (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axi       (bus),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_idx  (mem_wr_idx),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .beats_served(beats_served)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] ref_mem [MEM_DEPTH];
  logic [31:0] exp_served = '0;

`ifdef AXI_RD_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] rr_pat;
    int          exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void expect_beat(input logic [31:0] addr, input int beat,
                                      output logic [63:0] d, output logic [1:0] r);
    longint unsigned idx;
    idx = longint'(addr >> 3) + longint'(beat);
    if (idx >= MEM_DEPTH) begin
      d = '0;
      r = 2'b10;
    end else begin
      d = ref_mem[int'(idx)];
      r = 2'b00;
    end
  endfunction

  task automatic preload(input int idx, input logic [63:0] d);
    @(negedge clk);
    mem_wr_en   = 1'b1;
    mem_wr_idx  = idx[9:0];
    mem_wr_data = d;
    ref_mem[idx] = d;
    @(negedge clk);
    mem_wr_en = 1'b0;
  endtask

  // exp_err < 0 skips the SLVERR count check (random bursts).
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] rr_pat, input int exp_err, input string tag);
    int          beat = 0;
    int          cyc = 0;
    int          errs = 0;
    bit          gap_exp = 0;
    logic [63:0] ed;
    logic [1:0]  er;
    @(negedge clk);
    chk({tag, "_arready_idle"}, bus.arready, 1'b1);
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    bus.araddr  = $urandom;
    bus.arlen   = 8'($urandom);
    while (beat <= int'(len) && cyc < 2000) begin
      @(negedge clk);
      bus.rready = rr_pat[cyc % 32];
      chk({tag, "_rvalid"}, bus.rvalid, !gap_exp);
      chk({tag, "_arready_busy"}, {bus.arready, busy}, 2'b01);
      gap_exp = 0;
      if (bus.rvalid) begin
        expect_beat(addr, beat, ed, er);
        chk({tag, "_rdata"}, bus.rdata, ed);
        chk({tag, "_rresp"}, bus.rresp, er);
        chk({tag, "_rlast"}, bus.rlast, beat == int'(len));
        if (bus.rready) begin
          exp_served++;
          if (er == 2'b10) errs++;
`ifdef AXI_RD_STALL_EN
          if (beat != int'(len)) gap_exp = m_lfsr[0];
`endif
          beat++;
        end
      end
      cyc++;
    end
    if (cyc >= 2000) chk({tag, "_timeout"}, 1'b1, 1'b0);
    @(negedge clk);
    bus.rready = 1'b0;
    chk({tag, "_end_rvalid_rlast"}, {bus.rvalid, bus.rlast}, 2'b00);
    chk({tag, "_end_arready_busy"}, {bus.arready, busy}, 2'b10);
    chk({tag, "_beats_served"}, beats_served, exp_served);
    if (exp_err >= 0) chk({tag, "_slverr_beats"}, errs, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old_val;
    logic [63:0] new_val;

    vecs[0] = '{addr: 32'h0000_0000, len: 8'd0,   rr_pat: 32'hFFFF_FFFF, exp_err: 0};
    vecs[1] = '{addr: 32'h0000_0010, len: 8'd3,   rr_pat: 32'hFFFF_FFFF, exp_err: 0};
    vecs[2] = '{addr: 32'h0000_0010, len: 8'd3,   rr_pat: 32'h9999_9999, exp_err: 0};
    vecs[3] = '{addr: 32'h0000_1FF0, len: 8'd3,   rr_pat: 32'hFFFF_FFFF, exp_err: 2};
    vecs[4] = '{addr: 32'h0000_1FF4, len: 8'd1,   rr_pat: 32'h5555_5555, exp_err: 0};
    vecs[5] = '{addr: 32'h0000_2000, len: 8'd0,   rr_pat: 32'hFFFF_FFFF, exp_err: 1};
    vecs[6] = '{addr: 32'h0000_01F8, len: 8'd255, rr_pat: 32'hF0F0_F0F1, exp_err: 0};

    bus.araddr  = '0;
    bus.arlen   = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_arready", bus.arready, 1'b0);
    chk("reset_rvalid_rlast", {bus.rvalid, bus.rlast}, 2'b00);
    chk("reset_rdata", bus.rdata, 64'h0);
    chk("reset_rresp", bus.rresp, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_beats_served", beats_served, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_arready", bus.arready, 1'b1);

    @(negedge clk);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_wr_en   = 1'b1;
      mem_wr_idx  = i[9:0];
      mem_wr_data = (i < 16) ? 64'(i) : {$urandom, $urandom};
      ref_mem[i]  = mem_wr_data;
      @(negedge clk);
    end
    mem_wr_en = 1'b0;

    for (int v = 0; v < 7; v++) begin
      do_burst(vecs[v].addr, vecs[v].len, vecs[v].rr_pat, vecs[v].exp_err, $sformatf("vec%0d", v));
    end

    // Preload and fetch of the same word on one edge: the beat carries the old word.
    old_val = ref_mem[8];
    new_val = 64'hC0FF_EE00_1234_5678;
    @(negedge clk);
    bus.araddr  = 32'h40;
    bus.arlen   = 8'd0;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    mem_wr_en   = 1'b1;
    mem_wr_idx  = 10'd8;
    mem_wr_data = new_val;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    mem_wr_en   = 1'b0;
    @(negedge clk);
    chk("collide_rvalid", bus.rvalid, 1'b1);
    chk("collide_rdata_old", bus.rdata, old_val);
    exp_served++;
    ref_mem[8] = new_val;
    @(negedge clk);
    bus.rready = 1'b0;
    do_burst(32'h40, 8'd0, 32'hFFFF_FFFF, 0, "collide_reread");

    for (int n = 0; n < 20; n++) begin
      int k;
      k = int'($urandom_range(0, 1023));
      preload(k, {$urandom, $urandom});
      do_burst(32'($urandom_range(0, 1040)) * 32'd8 + 32'($urandom_range(0, 7)),
               8'($urandom_range(0, 20)), $urandom | 32'h1, -1, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset while beat 2 of an 8-beat burst is on the bus.
    preload(0, 64'hDEAD_BEEF_0BAD_F00D);
    @(negedge clk);
    bus.araddr  = 32'h0;
    bus.arlen   = 8'd7;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
    repeat (3) @(negedge clk);
`ifndef AXI_RD_STALL_EN
    chk("midrst_pre_rdata", bus.rdata, ref_mem[2]);
`endif
    chk("midrst_pre_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid_rlast", {bus.rvalid, bus.rlast}, 2'b00);
    chk("midrst_arready_busy", {bus.arready, busy}, 2'b00);
    chk("midrst_beats_served", beats_served, 32'h0);
    exp_served = '0;
    bus.rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_arready", bus.arready, 1'b1);
    do_burst(32'h0, 8'd0, 32'hFFFF_FFFF, 0, "midrst_reread");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_graph_mem_rd_slave.md
Name: axi4_graph_mem_rd_slave

Overview:
- AXI4 read-only responder, 64-bit data. Models the graph memory that the BFS engine's AXI4 read master fetches adjacency and frontier data from.
- Serves INCR bursts from an internal word array. The array is loaded through a simple preload write port driven by the bench or by PS-side init logic.
- Sits on the far end of the accelerator's m_axi read channel in system-level simulation and in FPGA loopback builds.

Parameters:
- ADDR_WIDTH, 32, width of araddr (byte address).
- DATA_WIDTH, 64, width of rdata; fixed at 64, so 8 bytes per beat.
- MEM_DEPTH, 1024, number of 64-bit words in the array.
- IDX_WIDTH, 10, preload index width; must satisfy 2^IDX_WIDTH >= MEM_DEPTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_araddr  in  ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  burst length minus 1 (1..256 beats).
- s_axi_arvalid  in  1  address valid.
- s_axi_arready  out  1  address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_rlast  out  1  final beat of the burst.
- s_axi_rvalid  out  1  data valid.
- s_axi_rready  in  1  data ready.
- mem_wr_en  in  1  preload write strobe.
- mem_wr_idx  in  IDX_WIDTH  preload word index.
- mem_wr_data  in  DATA_WIDTH  preload word.
- busy  out  1  high while a burst is in progress.
- beats_served  out  32  count of completed R handshakes.

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rdata=0, rresp=00, busy=0, beats_served=0. Reset deassertion leads to IDLE with arready=1 on the next clk edge. Memory contents are not reset.
- States:
  - IDLE: arready=1, busy=0.
  - BURST: arready=0, busy=1.
- IDLE → BURST on arvalid&&arready at edge T:
  - Latch word index = araddr >> 3 (low 3 bits ignored, unaligned addresses treated as aligned).
  - Latch len = arlen; beat counter = 0.
  - At T+1: rvalid=1, rdata = mem[idx], rlast = (arlen==0).
- Address-to-first-data latency is 1 cycle.
- BURST, on rvalid&&rready:
  - beats_served increments; it wraps at 2^32.
  - If beat counter == len: go to IDLE, rvalid=0 and rlast=0 next cycle, arready=1 next cycle.
  - Otherwise: idx+1 and counter+1; next cycle presents the next word with rvalid held at 1 (one beat per cycle under continuous rready). rlast=1 exactly when the counter equals len.
- Back-pressure: while rvalid && !rready, rdata, rresp and rlast hold stable. rvalid never drops before its handshake.
- Range check per beat: idx >= MEM_DEPTH gives rdata=0 and rresp=10 for that beat. Other beats of the same burst stay OKAY. The burst always completes with full length and a correct rlast.
- Index arithmetic is ADDR_WIDTH-3 bits wide with no wrap into range. No 4 KB boundary check.
- Only one burst is outstanding; arready=0 throughout BURST. The earliest next AR acceptance is the cycle after the last beat.
- Preload writes are accepted in any state. If a preload write and a beat fetch hit the same word on the same edge, the beat returns the pre-write data. Writes with mem_wr_idx >= MEM_DEPTH are ignored.
- Asynchronous reset mid-burst: rvalid and rlast drop immediately, the burst is abandoned, and the block returns to IDLE.

Optional Feature:
- Macro: AXI_RD_STALL_EN.
- When defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every cycle. After a non-last beat handshake, if lfsr[0]==1, rvalid deasserts for exactly one cycle before the next beat. Never inserted before beat 0, never while rvalid is high.
- When undefined: no LFSR logic, and continuous one-beat-per-cycle bursts as specified above.

Test Plan:
- Preload mem[0..3] = 64'h0..3; read araddr=0x0, arlen=0, rready=1 → one beat at T+1, rdata=0, rlast=1, rresp=00, beats_served=1.
- araddr=0x10, arlen=3, rready=1 → beats 2,3,4,5 (mem[5] preloaded 5) on consecutive cycles, rlast only on beat 3, arready back to 1 the cycle after.
- Same burst with rready toggled 1,0,0,1,... → data held stable while stalled, 4 beats total, no duplicated or skipped words.
- MEM_DEPTH=1024, araddr=0x1FF0 (idx 1022), arlen=3 → beats 0,1 OKAY with data; beats 2,3 rdata=0, rresp=10; rlast on beat 3.
- Assert rst_n low during beat 2 of an 8-beat burst → rvalid=0 immediately; after release, arready=1 and a fresh read of idx 0 returns the preloaded value, so memory is preserved.
- With AXI_RD_STALL_EN: 16-beat burst with rready=1 → 16 beats in order, single-cycle bubbles matching the LFSR model, no bubble before beat 0, beats_served=16.
